// File: rtl/c_element_array.sv
// -----------------------------------------------------------------------------
// c_element_array
// Clocked array of WIDTH independent N_IN-input Muller C-elements, used as the
// handshake join / completion primitive of the synchronous emulation of the
// async pipeline control.
//
// Each lane sets when every input selected by PLUS_MASK is 1 and clears when
// every input selected by MINUS_MASK is 0; otherwise it holds. Only the
// condition that matters for the current state is looked at, so a lane with
// disjoint masks and both conditions true toggles every enabled cycle.
// A per-lane watchdog raises a sticky err bit when the masked inputs of a lane
// stay in disagreement for TIMEOUT enabled cycles (TIMEOUT = 0 disables it).
//
// Ports
//   clk      : clock
//   rst      : synchronous active-high reset (wins over en and err_clr)
//   en       : 1 = evaluate lanes; 0 = hold state/counters, pulses forced to 0
//   in       : lane-major inputs, lane i input j at bit i*N_IN+j
//   err_clr  : clears every err bit and watchdog counter (s is untouched)
//   s        : registered C-element outputs
//   rise     : one-cycle pulse, lane went 0->1 (same cycle the new s appears)
//   fall     : one-cycle pulse, lane went 1->0 (same cycle the new s appears)
//   all_set  : &s (combinational)
//   all_clr  : ~|s (combinational)
//   err      : sticky per-lane watchdog flag
// -----------------------------------------------------------------------------
module c_element_array #(
  parameter int              WIDTH      = 4,
  parameter int              N_IN       = 2,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter logic [N_IN-1:0] PLUS_MASK  = '1,
  parameter logic [N_IN-1:0] MINUS_MASK = '1,
  parameter int              TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH*N_IN-1:0] in,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      s,
  output logic [WIDTH-1:0]      rise,
  output logic [WIDTH-1:0]      fall,
  output logic                  all_set,
  output logic                  all_clr,
  output logic [WIDTH-1:0]      err
);

  // A zero TIMEOUT still needs a legal (1-bit) counter type; it is held at 0.
  localparam int             CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);
  localparam logic [N_IN-1:0] WD_MASK = PLUS_MASK | MINUS_MASK;
  localparam bit             WD_ON   = (TIMEOUT > 0);

  // Set condition: every plus-participating input is 1.
  function automatic logic lane_set(input logic [N_IN-1:0] x);
    return &(x | ~PLUS_MASK);
  endfunction

  // Clear condition: every minus-participating input is 0.
  function automatic logic lane_clr(input logic [N_IN-1:0] x);
    return &(~x | ~MINUS_MASK);
  endfunction

  // Disagreement: the inputs under either mask are neither all 1 nor all 0.
  function automatic logic lane_pending(input logic [N_IN-1:0] x);
    return ~(&(x | ~WD_MASK)) & ~(&(~x | ~WD_MASK));
  endfunction

  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic [WIDTH-1:0] err_r;
  logic [CW-1:0]    cnt_r [WIDTH];

  logic [WIDTH-1:0] s_nxt_s;
  logic [WIDTH-1:0] rise_nxt_s;
  logic [WIDTH-1:0] fall_nxt_s;
  logic [WIDTH-1:0] err_nxt_s;
  logic [CW-1:0]    cnt_nxt_s [WIDTH];
  logic [N_IN-1:0]  x_s;

  // Next-state computation for every lane: C-element state, pulses, watchdog.
  always_comb begin
    s_nxt_s    = s_r;
    rise_nxt_s = {WIDTH{1'b0}};
    fall_nxt_s = {WIDTH{1'b0}};
    err_nxt_s  = err_r;
    x_s        = {N_IN{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
    end

    for (int i = 0; i < WIDTH; i++) begin
      x_s = in[i*N_IN +: N_IN];

      // C-element: a set lane only looks at the clear condition and vice versa.
      if (en) begin
        if (s_r[i]) begin
          s_nxt_s[i]    = ~lane_clr(x_s);
          fall_nxt_s[i] = lane_clr(x_s);
        end else begin
          s_nxt_s[i]    = lane_set(x_s);
          rise_nxt_s[i] = lane_set(x_s);
        end
      end else begin
        s_nxt_s[i] = s_r[i];
      end

      // Watchdog: err samples the registered count, so it appears one cycle
      // after the count reaches CNT_MAX; err_clr beats a coincident timeout.
      if (!WD_ON) begin
        cnt_nxt_s[i] = {CW{1'b0}};
        err_nxt_s[i] = 1'b0;
      end else if (err_clr) begin
        cnt_nxt_s[i] = {CW{1'b0}};
        err_nxt_s[i] = 1'b0;
      end else if (en) begin
        if (cnt_r[i] == CNT_MAX) begin
          err_nxt_s[i] = 1'b1;
        end else begin
          err_nxt_s[i] = err_r[i];
        end
        if (!lane_pending(x_s)) begin
          cnt_nxt_s[i] = {CW{1'b0}};
        end else if (cnt_r[i] == CNT_MAX) begin
          cnt_nxt_s[i] = cnt_r[i];
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CW'(1'b1);
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
        err_nxt_s[i] = err_r[i];
      end
    end
  end

  // State registers with synchronous reset; reset drops any pending transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r    <= INIT;
      rise_r <= {WIDTH{1'b0}};
      fall_r <= {WIDTH{1'b0}};
      err_r  <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      s_r    <= s_nxt_s;
      rise_r <= rise_nxt_s;
      fall_r <= fall_nxt_s;
      err_r  <= err_nxt_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign s       = s_r;
  assign rise    = rise_r;
  assign fall    = fall_r;
  assign err     = err_r;
  assign all_set = &s_r;
  assign all_clr = ~|s_r;

endmodule
